ifetch: RTL and testbench
=========================

Name: ifetch

Overview:
- Instruction fetch stage, directly upstream of the core's control unit.
- Owns the program counter and issues 32-bit word reads on the memory port.
- Buffers fetched words with their PCs in a small FIFO and presents them to control over a valid/ready handshake.
- Handles branch/jump redirects (flush plus new PC) and flags misaligned redirect targets.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned
DEPTH, 2, prefetch FIFO entries (power of two, 2..8)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous reset, active-low (rst==0 at posedge resets the block)
mem_addr  output  32  word address of current fetch request
mem_read  output  1  fetch request active
mem_rdata  input  32  read data; valid when mem_ready==1
mem_ready  input  1  request completes this cycle; data sampled at this posedge
inst  output  32  instruction word at FIFO head
inst_pc  output  32  PC of inst
inst_valid  output  1  FIFO head valid
inst_ready  input  1  control consumes head when inst_valid&&inst_ready
redirect  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  new PC
fault  output  1  misaligned redirect target; fetch halted

Behaviour:
- Reset (rst==0 at posedge):
  - fetch_pc=RESET_PC; FIFO empty (count=0, pointers 0); state=RUN.
  - mem_read=0, mem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fault=0.
  - Any in-flight request is abandoned.
- States:
  - RUN: normal fetching.
  - FAULT: no requests; inst_valid=0; fault=1.
- Request rule (RUN):
  - mem_read=1 whenever count<DEPTH, or count==DEPTH and a pop happens this cycle.
  - mem_read is registered: it is computed from next-cycle occupancy.
  - mem_addr=fetch_pc, stable while mem_read is high and mem_ready is low.
  - mem_read never drops mid-request except on redirect or reset.
- Completion:
  - At a posedge with mem_read&&mem_ready: push {fetch_pc, mem_rdata}; fetch_pc+=4.
  - 32-bit wrap: 0xFFFF_FFFC -> 0x0000_0000.
- Output side:
  - inst, inst_pc and inst_valid come directly from the FIFO head registers (no combinational path from mem_rdata).
  - Pop at posedge when inst_valid&&inst_ready.
- Same-cycle push and pop: count unchanged; order preserved.
- Push when full cannot occur: the request rule prevents it.
- Latency and throughput:
  - First mem_read=1 in the first cycle after rst returns high.
  - With mem_ready tied 1 and inst_ready tied 1: inst_valid rises 1 cycle after the first accepted read, then one instruction per cycle, no bubbles.
- Back-pressure:
  - With inst_ready=0, exactly DEPTH words are fetched, then mem_read=0.
  - Fetch resumes in the cycle after the first pop.
- Redirect (priority over everything except reset):
  - At a posedge with redirect==1: FIFO flushed (count=0); a coincident pop and a coincident mem_ready are both discarded.
  - Aligned target (redirect_pc[1:0]==0): fetch_pc=redirect_pc.
  - Next cycle: inst_valid=0; mem_read=1 with mem_addr=redirect_pc.
  - redirect held for several cycles: each cycle re-flushes; the last value wins.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - Enter FAULT: fault=1 next cycle, mem_read=0, FIFO empty.
  - Exit only via an aligned redirect (fault=0 next cycle, fetch restarts) or reset.
  - A misaligned redirect while already in FAULT keeps FAULT.
- RESET_PC is never checked for alignment at runtime; a misaligned RESET_PC is a configuration error.

Test Plan:
- Reset and streaming:
  - Stimulus: rst low 2 cycles; memory words 0x1000_0013+n at addr 4n; mem_ready=1, inst_ready=1.
  - Required: mem_addr 0,4,8,…; inst_valid from cycle 2; inst_pc 0,4,8 with matching inst; one per cycle.
- Back-pressure:
  - Stimulus: inst_ready=0 for 10 cycles.
  - Required: exactly 2 reads (addr 0,4), then mem_read=0; the first pop resumes fetch at addr 8; no word lost or duplicated.
- Wait states:
  - Stimulus: mem_ready high only every 3rd cycle.
  - Required: mem_addr held stable while pending; inst_pc sequence 0,4,8 unchanged.
- Redirect under load:
  - Stimulus: FIFO full, request pending, redirect=1 with redirect_pc=0x200 in the same cycle as mem_ready and inst_ready.
  - Required: next cycle inst_valid=0 and mem_addr=0x200; the next delivered inst_pc is 0x200.
- Misaligned redirect:
  - Stimulus: redirect_pc=0x102.
  - Required: fault=1, mem_read=0, inst_valid=0 persistently; then redirect_pc=0x104 gives fault=0 and the next inst_pc is 0x104.
- Wrap and mid-run reset:
  - Stimulus: redirect to 0xFFFF_FFF8.
  - Required: inst_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
  - Stimulus: rst=0 mid-request.
  - Required: all outputs at reset values next cycle.

Source files
------------

// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: memory read port on one side, instruction
// handshake to control plus redirect/fault on the other.
interface ifetch_if;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;

  modport master (
    output mem_addr, mem_read, inst, inst_pc, inst_valid, fault,
    input  mem_rdata, mem_ready, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_addr, mem_read, inst, inst_pc, inst_valid, fault,
    output mem_rdata, mem_ready, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, issues word reads, buffers
// fetched words with their PCs in a small FIFO for the control unit,
// and handles redirects including misaligned-target faults.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic    clk,
  input logic    rst,
  ifetch_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [PW-1:0] P_ONE   = PW'(1);

  typedef enum logic {RUN, FAULT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          mem_read_q, mem_read_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic          push, pop, flush, inst_valid;

  assign inst_valid     = (count_q != '0);
  assign bus.inst_valid = inst_valid;
  assign bus.inst       = word_q[rd_ptr_q];
  assign bus.inst_pc    = pc_q[rd_ptr_q];
  assign bus.mem_addr   = fetch_pc_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.fault      = (state_q == FAULT);

  // Next state: redirect overrides any push/pop; the read request is
  // registered from next-cycle occupancy so a push can never hit a full FIFO.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_read_d = 1'b0;
    flush      = 1'b0;
    push       = mem_read_q && bus.mem_ready;
    pop        = inst_valid && bus.inst_ready;
    count_d    = count_q;
    if (push && !pop)
      count_d = count_q + C_ONE;
    else if (pop && !push)
      count_d = count_q - C_ONE;

    if (bus.redirect) begin
      flush   = 1'b1;
      push    = 1'b0;
      pop     = 1'b0;
      count_d = '0;
      if (bus.redirect_pc[1:0] == 2'b00) begin
        state_d    = RUN;
        fetch_pc_d = bus.redirect_pc;
        mem_read_d = 1'b1;
      end else begin
        state_d = FAULT;
      end
    end else if (state_q == RUN) begin
      if (push)
        fetch_pc_d = fetch_pc_q + 32'd4;
      mem_read_d = (count_d < DEPTH_C);
    end
  end

  // State, PC, request and FIFO registers; active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      mem_read_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_read_q <= mem_read_d;
      count_q    <= count_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          word_q[wr_ptr_q] <= bus.mem_rdata;
          pc_q[wr_ptr_q]   <= fetch_pc_q;
          wr_ptr_q         <= wr_ptr_q + P_ONE;
        end
        if (pop)
          rd_ptr_q <= rd_ptr_q + P_ONE;
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: memory returns 0x1000_0013 + (addr>>2).
module tb_ifetch;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ifetch_if bus();

  ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = 32'h1000_0013 + (bus.mem_addr >> 2);

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h1000_0013 + (pc >> 2);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic mrdy, input logic irdy);
    rst = 1'b0;
    bus.mem_ready = mrdy;
    bus.inst_ready = irdy;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b1, 1'b1);
    checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL reset mem_read: got %0b want 0", bus.mem_read); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset mem_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset inst_valid: got %0b want 0", bus.inst_valid); end
    checks++; if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin errors++; $display("FAIL reset inst/inst_pc: got %h/%h want 0/0", bus.inst, bus.inst_pc); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset fault: got %0b want 0", bus.fault); end
  endtask

  task automatic test_stream();
    do_reset(1'b1, 1'b1);
    step();
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL stream first: got rd=%0b addr=%h v=%0b want 1/0/0", bus.mem_read, bus.mem_addr, bus.inst_valid); end
    for (int n = 0; n < 6; n++) begin
      step();
      checks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4*n) || bus.inst !== word_at(32'(4*n)) || bus.mem_addr !== 32'(4*n+4)) begin
        errors++;
        $display("FAIL stream n=%0d: got v=%0b pc=%h inst=%h addr=%h want 1/%h/%h/%h", n, bus.inst_valid, bus.inst_pc, bus.inst, bus.mem_addr, 32'(4*n), word_at(32'(4*n)), 32'(4*n+4));
      end
    end
  endtask

  task automatic test_backpressure();
    int reads = 0;
    do_reset(1'b1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.mem_read && bus.mem_ready) reads++;
    end
    checks++; if (reads != 2) begin errors++; $display("FAIL bp reads: got %0d want 2", reads); end
    checks++; if (bus.mem_read !== 1'b0 || bus.inst_pc !== 32'h0 || bus.inst_valid !== 1'b1) begin errors++; $display("FAIL bp stall: got rd=%0b pc=%h v=%0b want 0/0/1", bus.mem_read, bus.inst_pc, bus.inst_valid); end
    bus.inst_ready = 1'b1;
    step();
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h8 || bus.inst_pc !== 32'h4) begin errors++; $display("FAIL bp resume: got rd=%0b addr=%h pc=%h want 1/8/4", bus.mem_read, bus.mem_addr, bus.inst_pc); end
    step();
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h8 || bus.inst !== word_at(32'h8)) begin errors++; $display("FAIL bp order: got v=%0b pc=%h inst=%h want 1/8/%h", bus.inst_valid, bus.inst_pc, bus.inst, word_at(32'h8)); end
  endtask

  task automatic test_wait_states();
    logic [31:0] prev_addr = '0;
    logic        prev_pend = 1'b0;
    logic [31:0] exp_pc = '0;
    int          got = 0;
    do_reset(1'b0, 1'b1);
    for (int c = 0; c < 16; c++) begin
      step();
      if (prev_pend) begin
        checks++;
        if (bus.mem_addr !== prev_addr || bus.mem_read !== 1'b1) begin errors++; $display("FAIL wait hold c=%0d: got rd=%0b addr=%h want 1/%h", c, bus.mem_read, bus.mem_addr, prev_addr); end
      end
      if (bus.inst_valid === 1'b1) begin
        checks++;
        if (bus.inst_pc !== exp_pc || bus.inst !== word_at(exp_pc)) begin errors++; $display("FAIL wait seq: got pc=%h inst=%h want %h/%h", bus.inst_pc, bus.inst, exp_pc, word_at(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      bus.mem_ready = (c % 3 == 2);
      prev_pend = bus.mem_read && !bus.mem_ready;
      prev_addr = bus.mem_addr;
    end
    checks++; if (got != 5) begin errors++; $display("FAIL wait count: got %0d want 5", got); end
  endtask

  task automatic test_redirect_load();
    do_reset(1'b1, 1'b0);
    step(); step(); step();
    bus.mem_ready = 1'b0;
    bus.inst_ready = 1'b1;
    step();
    checks++; if (bus.mem_read !== 1'b1 || bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h4) begin errors++; $display("FAIL redir setup: got rd=%0b v=%0b pc=%h want 1/1/4", bus.mem_read, bus.inst_valid, bus.inst_pc); end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    bus.mem_ready = 1'b1;
    step();
    bus.redirect = 1'b0;
    checks++; if (bus.inst_valid !== 1'b0 || bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h200 || bus.fault !== 1'b0) begin errors++; $display("FAIL redir flush: got v=%0b rd=%0b addr=%h f=%0b want 0/1/200/0", bus.inst_valid, bus.mem_read, bus.mem_addr, bus.fault); end
    step();
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h200 || bus.inst !== word_at(32'h200)) begin errors++; $display("FAIL redir next: got v=%0b pc=%h inst=%h want 1/200/%h", bus.inst_valid, bus.inst_pc, bus.inst, word_at(32'h200)); end
  endtask

  task automatic test_misaligned();
    do_reset(1'b1, 1'b1);
    step(); step();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h102;
    step();
    bus.redirect = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.fault !== 1'b1 || bus.mem_read !== 1'b0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL misalign c=%0d: got f=%0b rd=%0b v=%0b want 1/0/0", c, bus.fault, bus.mem_read, bus.inst_valid); end
      step();
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h106;
    step();
    checks++; if (bus.fault !== 1'b1 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL misalign again: got f=%0b rd=%0b want 1/0", bus.fault, bus.mem_read); end
    bus.redirect_pc = 32'h104;
    step();
    bus.redirect = 1'b0;
    checks++; if (bus.fault !== 1'b0 || bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h104 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL misalign exit: got f=%0b rd=%0b addr=%h v=%0b want 0/1/104/0", bus.fault, bus.mem_read, bus.mem_addr, bus.inst_valid); end
    step();
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h104) begin errors++; $display("FAIL misalign restart: got v=%0b pc=%h want 1/104", bus.inst_valid, bus.inst_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc = 32'hFFFF_FFF8;
    do_reset(1'b1, 1'b1);
    step(); step();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    step();
    bus.redirect = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc || bus.inst !== word_at(exp_pc)) begin errors++; $display("FAIL wrap n=%0d: got v=%0b pc=%h inst=%h want 1/%h/%h", n, bus.inst_valid, bus.inst_pc, bus.inst, exp_pc, word_at(exp_pc)); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1'b1, 1'b0);
    step(); step();
    checks++; if (bus.inst_valid !== 1'b1 || bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h4) begin errors++; $display("FAIL midrst setup: got v=%0b rd=%0b addr=%h want 1/1/4", bus.inst_valid, bus.mem_read, bus.mem_addr); end
    bus.mem_ready = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_addr !== 32'h0 || bus.inst_valid !== 1'b0 || bus.inst !== 32'h0 || bus.inst_pc !== 32'h0 || bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL midrst outputs: got rd=%0b addr=%h v=%0b inst=%h pc=%h f=%0b want all 0", bus.mem_read, bus.mem_addr, bus.inst_valid, bus.inst, bus.inst_pc, bus.fault);
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    bus.inst_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_wait_states();
    test_redirect_load();
    test_misaligned();
    test_wrap();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
